// File: rtl/ece453_avalon_master_pkg.sv
// Shared types and constants for the ece453 Avalon-MM master: FSM encoding,
// response error codes and the ece453 slave register map.
package ece453_avalon_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic RSP_ERR_NONE    = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

    localparam logic [4:0] DEV_ID_ADDR   = 5'd0;
    localparam logic [4:0] GPIO_IN_ADDR  = 5'd1;
    localparam logic [4:0] GPIO_OUT_ADDR = 5'd2;
    localparam logic [4:0] CONTROL_ADDR  = 5'd3;
    localparam logic [4:0] IM_ADDR       = 5'd4;
    localparam logic [4:0] IRQ_ADDR      = 5'd5;

    localparam logic [31:0] DEV_ID_VALUE = 32'hECE4_5318;

    // One extra bit above $clog2 so a counter can hold its terminal value.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/ece453_avalon_master_if.sv
// Avalon-MM bus between the ece453 master and a register slave.
interface ece453_avalon_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   master_address;
    logic                master_read;
    logic                master_write;
    logic [DATA_W-1:0]   master_writedata;
    logic [DATA_W/8-1:0] master_byteenable;
    logic [DATA_W-1:0]   master_readdata;
    logic                master_waitrequest;

    modport master (
        output master_address, master_read, master_write,
        output master_writedata, master_byteenable,
        input  master_readdata, master_waitrequest
    );

    modport slave (
        input  master_address, master_read, master_write,
        input  master_writedata, master_byteenable,
        output master_readdata, master_waitrequest
    );
endinterface

// File: rtl/ece453_avm_counter.sv
// Loadable saturating up-counter with clear, enable and terminal-count compare.
module ece453_avm_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] tc_value,
    output logic             at_tc
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_tc = (count_q == tc_value);
endmodule

// File: rtl/ece453_avalon_master.sv
// Avalon-MM master: turns valid/ready commands into single Avalon transfers
// and returns one response per command, with a waitrequest timeout.
module ece453_avalon_master
    import ece453_avalon_master_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [DATA_W-1:0]   cmd_writedata,
    input  logic [DATA_W/8-1:0] cmd_byteenable,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_readdata,
    output logic                rsp_error,
    output logic                busy,
    ece453_avalon_master_if.master avm
);
    localparam int WAIT_W  = cnt_width(TIMEOUT_CYCLES);
    localparam int WAIT_TC = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int LAT_W   = cnt_width(READ_LATENCY);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic wait_clr, wait_en, wait_at_tc;
    logic lat_load, lat_en, lat_at_tc;
    logic timeout_hit;

    ece453_avm_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk        (clk),
        .srst       (reset),
        .clr        (wait_clr),
        .load       (1'b0),
        .en         (wait_en),
        .load_value ('0),
        .tc_value   (WAIT_W'(WAIT_TC)),
        .at_tc      (wait_at_tc)
    );

    ece453_avm_counter #(.WIDTH(LAT_W)) u_lat_cnt (
        .clk        (clk),
        .srst       (reset),
        .clr        (1'b0),
        .load       (lat_load),
        .en         (lat_en),
        .load_value (LAT_W'(1)),
        .tc_value   (LAT_W'(READ_LATENCY)),
        .at_tc      (lat_at_tc)
    );

    // The stall counter holds the cycles already stalled, so this cycle is the
    // TIMEOUT_CYCLES-th stalled one when it reads TIMEOUT_CYCLES-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && avm.master_waitrequest && wait_at_tc;
    assign wait_en     = ((state_q == WRITE) || (state_q == READ)) && avm.master_waitrequest;
    assign lat_en      = (state_q == RD_WAIT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        wait_clr = 1'b0;
        lat_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d   = cmd_address;
                    wdata_d  = cmd_writedata;
                    be_d     = cmd_byteenable;
                    wait_clr = 1'b1;
                    state_d  = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (!avm.master_waitrequest) begin
                    rdata_d = '0;
                    err_d   = RSP_ERR_NONE;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = RSP_ERR_TIMEOUT;
                    state_d = RESP;
                end
            end
            READ: begin
                if (!avm.master_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        rdata_d = avm.master_readdata;
                        err_d   = RSP_ERR_NONE;
                        state_d = RESP;
                    end else begin
                        lat_load = 1'b1;
                        state_d  = RD_WAIT;
                    end
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = RSP_ERR_TIMEOUT;
                    state_d = RESP;
                end
            end
            RD_WAIT: begin
                // Counter reads N in the N-th cycle after the acceptance cycle.
                if (lat_at_tc) begin
                    rdata_d = avm.master_readdata;
                    err_d   = RSP_ERR_NONE;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset gates cmd_ready so every output is 0 while reset is held.
    assign cmd_ready    = (state_q == IDLE) && !reset;
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_readdata = rdata_q;
    assign rsp_error    = err_q;

    assign avm.master_write      = (state_q == WRITE);
    assign avm.master_read       = (state_q == READ);
    assign avm.master_address    = ((state_q == WRITE) || (state_q == READ)) ? addr_q : '0;
    assign avm.master_writedata  = (state_q == WRITE) ? wdata_q : '0;
    assign avm.master_byteenable = (state_q == WRITE) ? be_q :
                                   (state_q == READ)  ? '1   : '0;
endmodule
